sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. It is the next-generation successor to the team's fixed 8-bit, 16-entry FIFOs. It adds configurable width and depth, an occupancy count, almost-full and almost-empty thresholds, overflow and underflow error pulses, and an optional first-word-fall-through (FWFT) read mode. It buffers data between a producer and a consumer in the same clock domain.

---
 rtl/sync_fifo_param.sv | 177 +++++++++++++++++
 tb/tb_sync_fifo_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Single-clock FIFO with configurable width and depth. It provides an occupancy
// count, almost-full and almost-empty thresholds, one-cycle overflow and
// underflow pulses, and an optional first-word-fall-through read mode.
//
// Parameters
//   DATA_W     data word width in bits (>= 1)
//   DEPTH      number of entries, a power of 2 and >= 2
//   AF_THRESH  almost_full asserts while count >= AF_THRESH
//   AE_THRESH  almost_empty asserts while count <= AE_THRESH
//   FWFT       0: rd_data updates one cycle after an accepted read
//              1: rd_data always shows the head word (0 when empty)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active low
//   wr_en/wr_data write request and data
//   rd_en         read request (FWFT=1: pops the displayed word)
//   rd_data       read data (registered)
//   full, empty, almost_full, almost_empty  registered occupancy flags
//   count         registered occupancy, 0..DEPTH
//   overflow      one-cycle pulse after a dropped write
//   underflow     one-cycle pulse after a rejected read
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    // Reject non power-of-two depths at elaboration time.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
    end

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              full_r;
    logic              empty_r;
    logic              almost_full_r;
    logic              almost_empty_r;
    logic              overflow_r;
    logic              underflow_r;

    logic              wr_ok_s;
    logic              rd_ok_s;
    logic [PTR_W-1:0]  wr_ptr_next_s;
    logic [PTR_W-1:0]  rd_ptr_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [DATA_W-1:0] rd_data_next_s;

    // Accept decisions from pre-edge state; a write at full rides on a same-cycle pop.
    always_comb begin
        rd_ok_s = rd_en & ~empty_r;
        wr_ok_s = wr_en & (~full_r | rd_ok_s);
    end

    // Next pointers and next occupancy.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        if (wr_ok_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (rd_ok_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Next read data. In FWFT mode the head word is precomputed so rd_data stays
    // registered: when the slot that becomes the head is being written on this
    // same edge (empty FIFO, or a pop of the last word alongside a write), the
    // incoming word is forwarded instead of the stale memory contents.
    always_comb begin
        rd_data_next_s = rd_data_r;
        if (FWFT != 0) begin
            if (count_next_s == '0) begin
                rd_data_next_s = '0;
            end else if (wr_ok_s && (wr_ptr_r == rd_ptr_next_s)) begin
                rd_data_next_s = wr_data;
            end else begin
                rd_data_next_s = mem_r[rd_ptr_next_s];
            end
        end else begin
            if (rd_ok_s) begin
                rd_data_next_s = mem_r[rd_ptr_r];
            end else begin
                rd_data_next_s = rd_data_r;
            end
        end
    end

    // Storage array; not cleared by reset, and reset blocks a concurrent write.
    always_ff @(posedge clk) begin
        if (rst && wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, count, read data, flags and error pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            rd_data_r      <= '0;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            wr_ptr_r       <= wr_ptr_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            count_r        <= count_next_s;
            rd_data_r      <= rd_data_next_s;
            // Flags are decoded from the next count so they line up with count_r.
            full_r         <= (count_next_s == DEPTH_C);
            empty_r        <= (count_next_s == '0);
            almost_full_r  <= (count_next_s >= AF_C);
            almost_empty_r <= (count_next_s <= AE_C);
            overflow_r     <= wr_en & ~wr_ok_s;
            underflow_r    <= rd_en & ~rd_ok_s;
        end
    end

    assign rd_data      = rd_data_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Directed bench for sync_fifo_param. Inputs are driven on the falling edge.
// A reference model captures accepted writes into a scoreboard queue at each
// rising edge; a separate monitor pops that queue whenever a read was accepted
// and compares rd_data, count, flags and error pulses every cycle. Directed
// checks with hand-computed values cover the boundary cases, and a second
// instance exercises FWFT mode.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_wr_en, f_rd_en;
    logic [7:0] f_wr_data;
    logic [7:0] f_rd_data;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int         m_count   = 0;
    logic [7:0] exp_q[$];
    logic       m_rd_pend = 1'b0;
    logic       m_ovf     = 1'b0;
    logic       m_udf     = 1'b0;
    logic [7:0] m_rd_data = 8'h00;
    logic       m_valid   = 1'b0;
    int         n_popped  = 0;
    logic [7:0] last_pop  = 8'h00;
    int         max_count = 0;
    int         n_err_seen = 0;

    // Model: applies the accept rules to the pre-edge model state.
    always @(posedge clk) begin : model
        bit w_ok;
        bit r_ok;
        if (!rst) begin
            m_count   = 0;
            exp_q.delete();
            m_rd_pend = 1'b0;
            m_ovf     = 1'b0;
            m_udf     = 1'b0;
            m_rd_data = 8'h00;
            m_valid   = 1'b1;
        end else begin
            r_ok = rd_en && (m_count != 0);
            w_ok = wr_en && ((m_count != DEPTH) || r_ok);
            if (w_ok) exp_q.push_back(wr_data);
            m_count   = m_count + int'(w_ok) - int'(r_ok);
            m_ovf     = wr_en && !w_ok;
            m_udf     = rd_en && !r_ok;
            m_rd_pend = r_ok;
            if (m_count > max_count) max_count = m_count;
        end
    end

    // Monitor: pops the scoreboard on each accepted read and checks all outputs.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            if (m_rd_pend) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underrun: read accepted with empty scoreboard (t=%0t)", $time);
                end else begin
                    m_rd_data = exp_q.pop_front();
                    last_pop  = m_rd_data;
                    n_popped++;
                end
            end
            if (overflow || underflow) n_err_seen++;
            check("mon_rd_data",      rd_data,      m_rd_data);
            check("mon_count",        count,        m_count);
            check("mon_full",         full,         m_count == DEPTH);
            check("mon_empty",        empty,        m_count == 0);
            check("mon_almost_full",  almost_full,  m_count >= 12);
            check("mon_almost_empty", almost_empty, m_count <= 4);
            check("mon_overflow",     overflow,     m_ovf);
            check("mon_underflow",    underflow,    m_udf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic we, input logic [7:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic fstep(input logic we, input logic [7:0] wd, input logic re);
        f_wr_en   = we;
        f_wr_data = wd;
        f_rd_en   = re;
        @(negedge clk);
        f_wr_en = 1'b0;
        f_rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        int errs0;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 8'h00;

        // 1. reset for two edges, then write 1..10
        repeat (2) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_ovf_udf", {overflow, underflow}, 0);
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, i[7:0], 1'b0);
            if (i == 1) check("t1_empty_after_first", empty, 0);
            if (i == 4) check("t1_ae_at4", almost_empty, 1);
            if (i == 5) check("t1_ae_at5", almost_empty, 0);
        end
        check("t1_count10", count, 10);
        check("t1_full", full, 0);
        check("t1_af", almost_full, 0);

        // 2. fill to 16, then overflow with 17
        for (int i = 11; i <= 16; i++) begin
            step(1'b1, i[7:0], 1'b0);
            if (i == 11) check("t2_af_at11", almost_full, 0);
            if (i == 12) check("t2_af_at12", almost_full, 1);
            if (i == 15) check("t2_full_at15", full, 0);
        end
        check("t2_full", full, 1);
        check("t2_count16", count, 16);
        step(1'b1, 8'd17, 1'b0);
        check("t2_overflow", overflow, 1);
        check("t2_count_held", count, 16);
        step(1'b0, 8'h00, 1'b0);
        check("t2_overflow_one_cycle", overflow, 0);

        // 3. drain 16 words, then one underflow
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("t3_rd_data", rd_data, i);
        end
        step(1'b0, 8'h00, 1'b1);
        check("t3_underflow", underflow, 1);
        check("t3_rd_held", rd_data, 8'd16);
        check("t3_empty", empty, 1);
        check("t3_count0", count, 0);
        step(1'b0, 8'h00, 1'b0);
        check("t3_underflow_one_cycle", underflow, 0);

        // 4. simultaneous read/write at full and at empty
        for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + i[7:0], 1'b0);
        check("t4_full", full, 1);
        step(1'b1, 8'h55, 1'b1);
        check("t4_count_stays16", count, 16);
        check("t4_oldest", rd_data, 8'h80);
        check("t4_no_ovf", overflow, 0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (i == 15) check("t4_rd15", rd_data, 8'h8F);
            if (i == 16) check("t4_55_last", rd_data, 8'h55);
        end
        check("t4_empty", empty, 1);
        step(1'b1, 8'h33, 1'b1);
        check("t4_empty_wr_count1", count, 1);
        check("t4_empty_wr_udf", underflow, 1);
        check("t4_empty_rd_held", rd_data, 8'h55);
        step(1'b0, 8'h00, 1'b1);
        check("t4_read33", rd_data, 8'h33);
        check("t4_empty_after", empty, 1);

        // 5. wrap-around with 2:1 write:read, throttled reads near the top
        pops0 = n_popped;
        errs0 = n_err_seen;
        max_count = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, i[7:0], (i % 2 == 1) || (m_count >= 14));
        end
        for (int k = 0; k < 20 && m_count > 0; k++) step(1'b0, 8'h00, 1'b1);
        check("t5_drained", count, 0);
        check("t5_reads", n_popped - pops0, 40);
        check("t5_last", last_pop, 8'd39);
        check("t5_max_le16", max_count <= 16, 1);
        check("t5_no_err_pulses", n_err_seen - errs0, 0);

        // 6. reset mid-operation
        for (int i = 0; i < 7; i++) step(1'b1, 8'h10 + i[7:0], 1'b0);
        check("t6_count7", count, 7);
        rst = 1'b0;
        step(1'b1, 8'hEE, 1'b1);
        rst = 1'b1;
        check("t6_count0", count, 0);
        check("t6_empty", empty, 1);
        check("t6_rd_data0", rd_data, 8'h00);
        check("t6_ae", almost_empty, 1);
        step(1'b1, 8'hC3, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("t6_new_data", rd_data, 8'hC3);
        check("t6_empty_after", empty, 1);

        // FWFT instance
        check("f_empty_init", f_empty, 1);
        check("f_rd_init", f_rd_data, 8'h00);
        check("f_flags_init", {f_full, f_almost_full, f_almost_empty, f_overflow}, 4'b0010);
        fstep(1'b1, 8'hA5, 1'b0);
        check("f_empty_drop", f_empty, 0);
        check("f_head_same_cycle", f_rd_data, 8'hA5);
        fstep(1'b1, 8'h5A, 1'b0);
        check("f_head_held", f_rd_data, 8'hA5);
        check("f_count2", f_count, 2);
        fstep(1'b0, 8'h00, 1'b1);
        check("f_pop_next", f_rd_data, 8'h5A);
        check("f_count1", f_count, 1);
        fstep(1'b0, 8'h00, 1'b1);
        check("f_empty_after_pop", f_empty, 1);
        check("f_rd_zero", f_rd_data, 8'h00);
        fstep(1'b1, 8'h3C, 1'b1);
        check("f_empty_wr_udf", f_underflow, 1);
        check("f_empty_wr_head", f_rd_data, 8'h3C);
        check("f_empty_wr_count", f_count, 1);
        fstep(1'b0, 8'h00, 1'b1);
        check("f_final_empty", f_empty, 1);
        check("f_final_zero", f_rd_data, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
